// File: rtl/fetch_pkg.sv
// Shared definitions for the 19-bit processor fetch stage: widths, opcodes, FSM states.
package fetch_pkg;
    localparam int PC_W        = 12;
    localparam int INSTR_W     = 19;
    localparam int STACK_DEPTH = 8;
    localparam int SP_W        = $clog2(STACK_DEPTH) + 1;

    localparam logic [2:0] OP_BR = 3'b101;
    localparam logic [2:0] OP_CF = 3'b111;

    localparam logic [1:0] BR_Z  = 2'b00;
    localparam logic [1:0] BR_NZ = 2'b01;
    localparam logic [1:0] BR_C  = 2'b10;
    localparam logic [1:0] BR_NC = 2'b11;

    localparam logic [1:0] CF_JMP  = 2'b00;
    localparam logic [1:0] CF_JSB  = 2'b01;
    localparam logic [1:0] CF_RET  = 2'b10;
    localparam logic [1:0] CF_HALT = 2'b11;

    typedef enum logic [1:0] {FILL, RUN, HALT} state_t;
endpackage

// File: rtl/return_stack.sv
// Subroutine return-address stack; pointer counts entries, top of stack is read combinationally.
module return_stack
    import fetch_pkg::*;
(
    input  logic            clock,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] wdata,
    output logic [PC_W-1:0] rdata,
    output logic            full,
    output logic            empty
);
    logic [PC_W-1:0] r_mem [STACK_DEPTH];
    logic [SP_W-1:0] r_sp;
    logic [SP_W-2:0] w_top;

    assign full  = (r_sp == SP_W'(STACK_DEPTH));
    assign empty = (r_sp == '0);
    assign w_top = r_sp[SP_W-2:0] - (SP_W-1)'(1);
    assign rdata = r_mem[w_top];

    // Only the pointer is reset; stale entries are unreachable once it is zero.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_mem[r_sp[SP_W-2:0]] <= wdata;
            r_sp                  <= r_sp + SP_W'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, synchronous-read imem addressing, zero-bubble control flow, halt on HALT or stack fault.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic               clock,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               zero_flag,
    input  logic               carry_flag,
    output logic               halted,
    output logic [1:0]         stack_err
);
    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [1:0]      r_err;
    logic            r_valid;
    logic            r_halted;

    logic            w_accept;
    logic [2:0]      w_op;
    logic [1:0]      w_sub;
    logic [PC_W-1:0] w_tgt;
    logic [PC_W-1:0] w_inc;
    logic [PC_W-1:0] w_next;
    logic            w_push;
    logic            w_pop;
    logic            w_halt;
    logic            w_ovf;
    logic            w_unf;
    logic [PC_W-1:0] w_ret_addr;
    logic            w_full;
    logic            w_empty;

    assign w_accept = (r_state == RUN) && instr_ready;
    assign w_op     = imem_data[INSTR_W-1 -: 3];
    assign w_sub    = imem_data[INSTR_W-4 -: 2];
    assign w_tgt    = imem_data[PC_W-1:0];
    assign w_inc    = r_pc + PC_W'(1);

    // Decode the word currently presented; halting cases leave the PC where it is.
    always_comb begin
        w_next = w_inc;
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_halt = 1'b0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        if (w_op == OP_BR) begin
            unique case (w_sub)
                BR_Z:  if (zero_flag)   w_next = w_tgt;
                BR_NZ: if (!zero_flag)  w_next = w_tgt;
                BR_C:  if (carry_flag)  w_next = w_tgt;
                BR_NC: if (!carry_flag) w_next = w_tgt;
            endcase
        end else if (w_op == OP_CF) begin
            unique case (w_sub)
                CF_JMP: w_next = w_tgt;
                CF_JSB: begin
                    if (w_full) begin
                        w_ovf  = 1'b1;
                        w_halt = 1'b1;
                        w_next = r_pc;
                    end else begin
                        w_push = 1'b1;
                        w_next = w_tgt;
                    end
                end
                CF_RET: begin
                    if (w_empty) begin
                        w_unf  = 1'b1;
                        w_halt = 1'b1;
                        w_next = r_pc;
                    end else begin
                        w_pop  = 1'b1;
                        w_next = w_ret_addr;
                    end
                end
                CF_HALT: begin
                    w_halt = 1'b1;
                    w_next = r_pc;
                end
            endcase
        end
    end

    return_stack u_stack (
        .clock (clock),
        .rst   (rst),
        .push  (w_accept && w_push),
        .pop   (w_accept && w_pop),
        .wdata (w_inc),
        .rdata (w_ret_addr),
        .full  (w_full),
        .empty (w_empty)
    );

    // Redirecting the address in the accept cycle is what makes taken flow bubble-free.
    assign imem_addr   = w_accept ? w_next : r_pc;
    assign instr       = imem_data;
    assign instr_pc    = r_pc;
    assign instr_valid = r_valid;
    assign halted      = r_halted;
    assign stack_err   = r_err;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state  <= FILL;
            r_pc     <= '0;
            r_err    <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            unique case (r_state)
                FILL: begin
                    r_state <= RUN;
                    r_valid <= 1'b1;
                end
                RUN: begin
                    if (w_accept) begin
                        if (w_halt) begin
                            r_state  <= HALT;
                            r_valid  <= 1'b0;
                            r_halted <= 1'b1;
                            r_err    <= r_err | {w_unf, w_ovf};
                        end else begin
                            r_pc <= w_next;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: r_state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vectors plus randomized programs vs an ISA-level model.
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] imem_addr;
    logic [18:0] imem_data = '0;
    logic [18:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        zero_flag = 1'b0;
    logic        carry_flag = 1'b0;
    logic        halted;
    logic [1:0]  stack_err;

    logic [18:0] mem [4096];
    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clock(clock), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted), .stack_err(stack_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) imem_data <= mem[imem_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [18:0] word;
        logic        z;
        logic        c;
        logic [11:0] exp_next;
    } br_vec_t;

    function automatic logic [18:0] mk(input logic [2:0] op, input logic [1:0] sub, input logic [11:0] t);
        return {op, sub, 2'b00, t};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 19'(i);
    endtask

    // Holds rst over one edge, checks reset state, releases rst mid-cycle.
    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(stack_err), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        rst = 1'b0;
    endtask

    task automatic expect_pc(input string nm, input logic [11:0] pc);
        @(negedge clock);
        chk({nm, "_valid"}, 32'(instr_valid), 32'd1);
        chk({nm, "_pc"}, 32'(instr_pc), 32'(pc));
        chk({nm, "_instr"}, 32'(instr), 32'(mem[pc]));
    endtask

    task automatic expect_halt(input string nm, input logic [1:0] err);
        @(negedge clock);
        chk({nm, "_valid"}, 32'(instr_valid), 32'd0);
        chk({nm, "_halted"}, 32'(halted), 32'd1);
        chk({nm, "_err"}, 32'(stack_err), 32'(err));
    endtask

    br_vec_t tbl[10];

    initial begin
        // ---------------- sequential fetch and stall ----------------
        clear_mem();
        do_reset();
        for (int i = 0; i <= 5; i++) expect_pc("seq", 12'(i));
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", 32'(instr_pc), 32'h5);
            chk("stall_instr", 32'(instr), 32'(mem[5]));
            chk("stall_addr", 32'(imem_addr), 32'h5);
        end
        instr_ready = 1'b1;
        expect_pc("after_stall", 12'h6);

        // ---------------- branch / jump table ----------------
        tbl[0] = '{"bz_t",   mk(3'b101, 2'b00, 12'h040), 1'b1, 1'b0, 12'h040};
        tbl[1] = '{"bz_n",   mk(3'b101, 2'b00, 12'h040), 1'b0, 1'b1, 12'h011};
        tbl[2] = '{"bnz_t",  mk(3'b101, 2'b01, 12'h040), 1'b0, 1'b0, 12'h040};
        tbl[3] = '{"bnz_n",  mk(3'b101, 2'b01, 12'h040), 1'b1, 1'b0, 12'h011};
        tbl[4] = '{"bc_t",   mk(3'b101, 2'b10, 12'h040), 1'b0, 1'b1, 12'h040};
        tbl[5] = '{"bc_n",   mk(3'b101, 2'b10, 12'h040), 1'b1, 1'b0, 12'h011};
        tbl[6] = '{"bnc_t",  mk(3'b101, 2'b11, 12'h040), 1'b1, 1'b0, 12'h040};
        tbl[7] = '{"bnc_n",  mk(3'b101, 2'b11, 12'h040), 1'b0, 1'b1, 12'h011};
        tbl[8] = '{"jmp",    mk(3'b111, 2'b00, 12'h040), 1'b0, 1'b0, 12'h040};
        tbl[9] = '{"nop_br", mk(3'b110, 2'b00, 12'h040), 1'b1, 1'b1, 12'h011};
        for (int v = 0; v < 10; v++) begin
            clear_mem();
            mem[0]      = mk(3'b111, 2'b00, 12'h010);
            mem[12'h10] = tbl[v].word;
            zero_flag   = tbl[v].z;
            carry_flag  = tbl[v].c;
            do_reset();
            expect_pc({tbl[v].name, "_j"}, 12'h000);
            expect_pc({tbl[v].name, "_at"}, 12'h010);
            chk({tbl[v].name, "_addr"}, 32'(imem_addr), 32'(tbl[v].exp_next));
            expect_pc(tbl[v].name, tbl[v].exp_next);
        end
        zero_flag = 1'b0;
        carry_flag = 1'b0;

        // ---------------- call / return, then underflow ----------------
        clear_mem();
        mem[0]       = mk(3'b111, 2'b00, 12'h020);
        mem[12'h020] = mk(3'b111, 2'b01, 12'h100);
        mem[12'h100] = mk(3'b111, 2'b10, 12'h000);
        mem[12'h021] = mk(3'b111, 2'b10, 12'h000);
        do_reset();
        expect_pc("call0", 12'h000);
        expect_pc("call1", 12'h020);
        expect_pc("call2", 12'h100);
        expect_pc("call3", 12'h021);
        expect_halt("ret_after_call", 2'b10);

        // ---------------- nine nested calls ----------------
        clear_mem();
        for (int i = 0; i < 9; i++) mem[i] = mk(3'b111, 2'b01, 12'(i + 1));
        do_reset();
        for (int i = 0; i < 9; i++) expect_pc("nest", 12'(i));
        expect_halt("overflow", 2'b01);

        // ---------------- return on empty stack ----------------
        clear_mem();
        mem[0] = mk(3'b111, 2'b10, 12'h000);
        do_reset();
        expect_pc("ret_empty0", 12'h000);
        expect_halt("underflow", 2'b10);

        // ---------------- HALT at top of memory, reset while halted ----------------
        clear_mem();
        mem[0]       = mk(3'b111, 2'b00, 12'hFFF);
        mem[12'hFFF] = mk(3'b111, 2'b11, 12'h000);
        do_reset();
        expect_pc("halt0", 12'h000);
        expect_pc("halt1", 12'hFFF);
        expect_halt("halt_op", 2'b00);
        repeat (3) @(negedge clock);
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_sticky_valid", 32'(instr_valid), 32'd0);
        do_reset();
        expect_pc("post_halt", 12'h000);

        // ---------------- PC wrap ----------------
        mem[12'hFFF] = 19'h00123;
        do_reset();
        expect_pc("wrap0", 12'h000);
        expect_pc("wrap1", 12'hFFF);
        expect_pc("wrap2", 12'h000);

        // ---------------- randomized programs vs ISA model ----------------
        for (int ep = 0; ep < 30; ep++) begin
            logic [11:0] m_pc;
            logic [1:0]  m_err;
            int          m_st;   // 0 filling, 1 running, 2 halted
            logic [11:0] stk[$];
            for (int i = 0; i < 4096; i++) begin
                int r, s, o;
                r = $urandom % 100;
                if (r < 55) begin
                    o = $urandom % 6;
                    mem[i] = {(o == 5) ? 3'd6 : 3'(o), 16'($urandom)};
                end else if (r < 75) begin
                    mem[i] = mk(3'b101, 2'($urandom), 12'($urandom));
                end else begin
                    s = $urandom % 20;
                    mem[i] = mk(3'b111, (s < 8) ? 2'd0 : (s < 14) ? 2'd1 : (s < 19) ? 2'd2 : 2'd3,
                                12'($urandom));
                end
            end
            instr_ready = 1'b1;
            do_reset();
            m_pc = '0; m_err = '0; m_st = 0; stk.delete();
            repeat (200) begin
                logic [18:0] w;
                logic [11:0] nxt, inc, t;
                logic        acc, hlt, taken;
                instr_ready = ($urandom % 4) != 0;
                zero_flag   = 1'($urandom);
                carry_flag  = 1'($urandom);
                #1;
                acc = (m_st == 1) && instr_ready;
                nxt = m_pc;
                hlt = 1'b0;
                if (acc) begin
                    w   = mem[m_pc];
                    t   = w[11:0];
                    inc = m_pc + 12'd1;
                    if (w[18:16] == 3'b101) begin
                        case (w[15:14])
                            2'd0:    taken = zero_flag;
                            2'd1:    taken = !zero_flag;
                            2'd2:    taken = carry_flag;
                            default: taken = !carry_flag;
                        endcase
                        nxt = taken ? t : inc;
                    end else if (w[18:16] == 3'b111) begin
                        case (w[15:14])
                            2'd0: nxt = t;
                            2'd1: if (stk.size() == 8) begin m_err[0] = 1'b1; hlt = 1'b1; end
                                  else begin stk.push_back(inc); nxt = t; end
                            2'd2: if (stk.size() == 0) begin m_err[1] = 1'b1; hlt = 1'b1; end
                                  else nxt = stk.pop_back();
                            default: hlt = 1'b1;
                        endcase
                    end else begin
                        nxt = inc;
                    end
                end
                if (m_st != 2 && !hlt) chk("rnd_addr", 32'(imem_addr), 32'(acc ? nxt : m_pc));
                if (m_st == 0) m_st = 1;
                else if (acc) begin
                    if (hlt) m_st = 2;
                    else m_pc = nxt;
                end
                @(negedge clock);
                chk("rnd_valid", 32'(instr_valid), 32'(m_st == 1));
                chk("rnd_halted", 32'(halted), 32'(m_st == 2));
                chk("rnd_err", 32'(stack_err), 32'(m_err));
                if (m_st == 1) begin
                    chk("rnd_pc", 32'(instr_pc), 32'(m_pc));
                    chk("rnd_instr", 32'(instr), 32'(mem[m_pc]));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 19-bit processor, directly upstream of the controller. Holds the program counter and drives a synchronous-read instruction memory. Presents each 19-bit instruction word to the controller/datapath with a valid/ready handshake. Resolves all control flow (conditional branches, jump, subroutine call/return through an internal return stack) with zero bubbles, and halts on a HALT opcode or a stack fault.

## Interface
- PC_W, 12, program counter / instruction address width
- INSTR_W, 19, instruction word width
- STACK_DEPTH, 8, return stack entries

- clock  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  PC_W  instruction memory read address, combinational; data returns one cycle later
- imem_data  in  INSTR_W  instruction memory read data, registered inside the memory
- instr  out  INSTR_W  current instruction; equals imem_data
- instr_pc  out  PC_W  address of instr (pc_q)
- instr_valid  out  1  instr is valid
- instr_ready  in  1  downstream accepts instr this cycle
- zero_flag, carry_flag  in  1 each  datapath flag registers
- halted  out  1  fetch stopped; sticky until rst
- stack_err  out  2  bit0 overflow, bit1 underflow; sticky until rst

## Operation
- accept = instr_valid & instr_ready. Control-flow decode uses instr[18:16] and instr[15:14]; target T = instr[11:0].
- 101: conditional branch. 00 BZ (zero_flag=1), 01 BNZ (zero_flag=0), 10 BC (carry_flag=1), 11 BNC (carry_flag=0). Taken → next = T, else pc_q+1. Flags sampled in the accept cycle.
- 111/00 JMP: next = T.
- 111/01 JSB: push pc_q+1, next = T. If stack full (8 entries): no push, no redirect, stack_err[0]=1, enter HALT.
- 111/10 RET: next = pop. If stack empty: stack_err[1]=1, enter HALT.
- 111/11 HALT: enter HALT, no redirect.
- All other opcodes: next = pc_q+1.
- pc_q+1 wraps 4095 → 0.
- Control-flow words are still presented to the downstream stage and accepted normally. The downstream stage treats them as no-ops.
- FSM:
  - FILL: instr_valid=0, imem_addr=pc_q → RUN next cycle.
  - RUN: instr_valid=1. On accept: imem_addr=next, pc_q<=next. Without accept: imem_addr=pc_q, so the word is held. A halting condition on accept → HALT.
  - HALT: instr_valid=0, imem_addr=pc_q, halted=1. Exits only on rst.
- Simultaneous push/pop cannot occur (one instruction per accept).

## Timing
- Reset values: pc_q=0, state FILL, stack pointer 0, instr_valid=0, halted=0, stack_err=0, imem_addr=0. rst at any time, including mid-stall or in HALT, aborts everything and clears the stack.
- Address 0 appears as valid instr in the 2nd cycle after rst deasserts.
- Throughput: one instruction per cycle while instr_ready=1, including taken branches, JMP, JSB and RET (zero bubbles).
- Stall: instr, instr_pc and instr_valid are stable while instr_ready=0.
- HALT: instr_valid falls in the cycle after the halting accept. halted and stack_err assert in that same cycle.

## Structure
- Shared package fetch_pkg: PC_W, INSTR_W, STACK_DEPTH, opcode constants (OP_BR=3'b101, OP_CF=3'b111), branch/CF sub-codes, state enum {FILL, RUN, HALT}.
- Sub-module return_stack:
  - 8×12 register array with 4-bit pointer.
  - Ports: push, pop, wdata, rdata, full, empty.
  - Synchronous reset; rdata is a combinational top-of-stack.

## Test plan
- Reset, then memory holding words 0..3 with non-CF opcodes, instr_ready=1 → instr_pc 0,1,2,3 on consecutive cycles starting the 2nd cycle after reset.
- Stall: instr_ready=0 for 3 cycles at pc 5 → instr, instr_pc=5 and imem_addr=5 held. The next accept advances to 6.
- BZ T=0x040 at pc 0x010:
  - zero_flag=1 → next instr_pc=0x040.
  - zero_flag=0 → 0x011.
  - BNC with carry_flag=0 → taken.
- JSB 0x100 at pc 0x020, RET at 0x100 → instr_pc sequence 0x020, 0x100, 0x021. Stack empty afterwards.
- Nine nested JSB → 9th sets stack_err=2'b01, halted=1, instr_valid=0. RET with empty stack after reset → stack_err=2'b10.
- HALT at pc 0xFFF → halted=1. Separately, a non-CF word at 0xFFF accepted → next instr_pc=0x000. rst while halted → FILL, pc 0.
